// File: rtl/gba_lcd_timing_pkg.sv
// Shared widths, default raster constants and BGR555 helpers for the GBA LCD timing block.
package gba_lcd_timing_pkg;

    localparam int CNT_W   = 9;
    localparam int COORD_W = 8;
    localparam int PIX_W   = 15;
    localparam int CH_W    = 5;

    localparam int H_ACTIVE_DEF = 240;
    localparam int H_FP_DEF     = 40;
    localparam int H_SYNC_DEF   = 40;
    localparam int H_BP_DEF     = 80;
    localparam int V_ACTIVE_DEF = 160;
    localparam int V_FP_DEF     = 40;
    localparam int V_SYNC_DEF   = 10;
    localparam int V_BP_DEF     = 50;

    // BGR555 packs red in the low bits and blue in the high bits.
    localparam int R_LSB = 0;
    localparam int G_LSB = 5;
    localparam int B_LSB = 10;

    typedef logic [CNT_W-1:0]   cnt_t;
    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [PIX_W-1:0]   pix_t;
    typedef logic [CH_W-1:0]    chan_t;

    typedef struct packed {
        chan_t r;
        chan_t g;
        chan_t b;
    } rgb_t;

    function automatic rgb_t bgr555_unpack(input pix_t pix);
        rgb_t c;
        c.r = pix[R_LSB +: CH_W];
        c.g = pix[G_LSB +: CH_W];
        c.b = pix[B_LSB +: CH_W];
        return c;
    endfunction

endpackage

// File: rtl/gba_lcd_timing_raster_counter.sv
// Horizontal/vertical dot counters for the LCD raster, with line and frame boundary strobes.
module gba_lcd_timing_raster_counter
    import gba_lcd_timing_pkg::*;
#(
    parameter int H_TOTAL = 400,
    parameter int V_TOTAL = 260
) (
    input  logic clk,
    input  logic rst,
    output cnt_t h_cnt,
    output cnt_t v_cnt,
    output logic line_start,
    output logic frame_origin
);

    localparam cnt_t H_LAST = cnt_t'(H_TOTAL - 1);
    localparam cnt_t V_LAST = cnt_t'(V_TOTAL - 1);

    cnt_t h_cnt_q, h_cnt_d;
    cnt_t v_cnt_q, v_cnt_d;
    logic line_end;
    logic frame_end;

    always_comb begin
        line_end  = (h_cnt_q == H_LAST);
        frame_end = line_end && (v_cnt_q == V_LAST);
        h_cnt_d   = line_end ? '0 : h_cnt_q + cnt_t'(1);
        v_cnt_d   = v_cnt_q;
        if (line_end) begin
            v_cnt_d = frame_end ? '0 : v_cnt_q + cnt_t'(1);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    assign h_cnt        = h_cnt_q;
    assign v_cnt        = v_cnt_q;
    assign line_start   = (h_cnt_q == '0);
    assign frame_origin = line_start && (v_cnt_q == '0);

endmodule

// File: rtl/gba_lcd_timing.sv
// GBA LCD raster timing: sync/status decode from the dot counters and a 2-stage fetch-to-panel pipeline.
module gba_lcd_timing
    import gba_lcd_timing_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    output logic        pix_req,
    output logic [7:0]  pix_x,
    output logic [7:0]  pix_y,
    input  logic [14:0] pix_data,
    output logic        lcd_hs,
    output logic        lcd_vs,
    output logic        lcd_de,
    output logic [4:0]  lcd_r,
    output logic [4:0]  lcd_g,
    output logic [4:0]  lcd_b,
    output logic [8:0]  vcount,
    input  logic [8:0]  vcount_target,
    output logic        hblank,
    output logic        vblank,
    output logic        vcount_match,
    output logic        frame_start,
    output logic        hblank_irq,
    output logic        vblank_irq,
    output logic        vcount_irq
);

    localparam int   H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int   V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam cnt_t H_ACT   = cnt_t'(H_ACTIVE);
    localparam cnt_t HS_BEG  = cnt_t'(H_ACTIVE + H_FP);
    localparam cnt_t HS_END  = cnt_t'(H_ACTIVE + H_FP + H_SYNC);
    localparam cnt_t V_ACT   = cnt_t'(V_ACTIVE);
    localparam cnt_t VS_BEG  = cnt_t'(V_ACTIVE + V_FP);
    localparam cnt_t VS_END  = cnt_t'(V_ACTIVE + V_FP + V_SYNC);

    cnt_t h_cnt;
    cnt_t v_cnt;
    logic line_start;
    logic frame_origin;

    gba_lcd_timing_raster_counter #(
        .H_TOTAL(H_TOTAL),
        .V_TOTAL(V_TOTAL)
    ) u_raster (
        .clk         (clk),
        .rst         (rst),
        .h_cnt       (h_cnt),
        .v_cnt       (v_cnt),
        .line_start  (line_start),
        .frame_origin(frame_origin)
    );

    logic h_active;
    logic v_active;
    logic hs_on;
    logic vs_on;

    always_comb begin
        h_active = (h_cnt < H_ACT);
        v_active = (v_cnt < V_ACT);
        hs_on    = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
        vs_on    = (v_cnt >= VS_BEG) && (v_cnt < VS_END);
    end

    // Status is zero-latency from the counters so CPU-side DISPSTAT sees the current dot.
    always_comb begin
        // NOTE: every output gets a default before the conditional, so no path infers a latch.
        vcount       = '0;
        hblank       = 1'b0;
        vblank       = 1'b0;
        vcount_match = 1'b0;
        frame_start  = 1'b0;
        hblank_irq   = 1'b0;
        vblank_irq   = 1'b0;
        vcount_irq   = 1'b0;
        if (!rst) begin
            vcount       = v_cnt;
            hblank       = !h_active;
            vblank       = !v_active;
            vcount_match = (v_cnt == vcount_target);
            frame_start  = frame_origin;
            hblank_irq   = (h_cnt == H_ACT);
            vblank_irq   = line_start && (v_cnt == V_ACT);
            vcount_irq   = line_start && (v_cnt == vcount_target);
        end
    end

    logic   pix_req_q, pix_req_d;
    coord_t pix_x_q, pix_x_d;
    coord_t pix_y_q, pix_y_d;
    logic   hs_s1_q, hs_s1_d;
    logic   vs_s1_q, vs_s1_d;
    logic   lcd_de_q, lcd_de_d;
    rgb_t   rgb_q, rgb_d;
    logic   lcd_hs_q, lcd_hs_d;
    logic   lcd_vs_q, lcd_vs_d;

    always_comb begin
        pix_req_d = h_active && v_active;
        pix_x_d   = pix_x_q;
        pix_y_d   = pix_y_q;
        if (pix_req_d) begin
            pix_x_d = h_cnt[COORD_W-1:0];
            pix_y_d = v_cnt[COORD_W-1:0];
        end
        hs_s1_d = hs_on ? HS_POL : ~HS_POL;
        vs_s1_d = vs_on ? VS_POL : ~VS_POL;

        // Syncs ride one extra stage so they stay aligned with the fetched pixel.
        lcd_de_d = pix_req_q;
        rgb_d    = pix_req_q ? bgr555_unpack(pix_data) : '0;
        lcd_hs_d = hs_s1_q;
        lcd_vs_d = vs_s1_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pix_req_q <= 1'b0;
            pix_x_q   <= '0;
            pix_y_q   <= '0;
            hs_s1_q   <= ~HS_POL;
            vs_s1_q   <= ~VS_POL;
            lcd_de_q  <= 1'b0;
            rgb_q     <= '0;
            lcd_hs_q  <= ~HS_POL;
            lcd_vs_q  <= ~VS_POL;
        end else begin
            pix_req_q <= pix_req_d;
            pix_x_q   <= pix_x_d;
            pix_y_q   <= pix_y_d;
            hs_s1_q   <= hs_s1_d;
            vs_s1_q   <= vs_s1_d;
            lcd_de_q  <= lcd_de_d;
            rgb_q     <= rgb_d;
            lcd_hs_q  <= lcd_hs_d;
            lcd_vs_q  <= lcd_vs_d;
        end
    end

    assign pix_req = pix_req_q;
    assign pix_x   = pix_x_q;
    assign pix_y   = pix_y_q;
    assign lcd_de  = lcd_de_q;
    assign lcd_r   = rgb_q.r;
    assign lcd_g   = rgb_q.g;
    assign lcd_b   = rgb_q.b;
    assign lcd_hs  = lcd_hs_q;
    assign lcd_vs  = lcd_vs_q;

endmodule

// File: tb/tb_gba_lcd_timing.sv
// Self-checking bench for gba_lcd_timing on a shortened raster (full 240-dot lines, few lines per frame).
module tb_gba_lcd_timing;

    localparam int H_ACTIVE = 240;
    localparam int H_FP     = 8;
    localparam int H_SYNC   = 8;
    localparam int H_BP     = 8;
    localparam int V_ACTIVE = 8;
    localparam int V_FP     = 2;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 2;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int FRAME    = H_TOTAL * V_TOTAL;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pix_req;
    logic [7:0]  pix_x, pix_y;
    logic [14:0] pix_data = '0;
    logic        lcd_hs, lcd_vs, lcd_de;
    logic [4:0]  lcd_r, lcd_g, lcd_b;
    logic [8:0]  vcount;
    logic [8:0]  vcount_target = 9'd5;
    logic        hblank, vblank, vcount_match;
    logic        frame_start, hblank_irq, vblank_irq, vcount_irq;

    int tests_run    = 0;
    int tests_failed = 0;

    gba_lcd_timing #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .HS_POL(1'b0), .VS_POL(1'b0)
    ) dut (
        .clk(clk), .rst(rst),
        .pix_req(pix_req), .pix_x(pix_x), .pix_y(pix_y), .pix_data(pix_data),
        .lcd_hs(lcd_hs), .lcd_vs(lcd_vs), .lcd_de(lcd_de),
        .lcd_r(lcd_r), .lcd_g(lcd_g), .lcd_b(lcd_b),
        .vcount(vcount), .vcount_target(vcount_target),
        .hblank(hblank), .vblank(vblank), .vcount_match(vcount_match),
        .frame_start(frame_start), .hblank_irq(hblank_irq),
        .vblank_irq(vblank_irq), .vcount_irq(vcount_irq)
    );

    initial forever #80 clk = ~clk;

    initial begin
        #(40 * FRAME * 160);
        $display("FAIL watchdog: simulation did not finish, tests_run=%0d", tests_run);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input longint actual, input longint expected);
        tests_run++;
        if (actual != expected) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic bit is_active(input int h, input int v);
        return (h < H_ACTIVE) && (v < V_ACTIVE);
    endfunction

    function automatic bit in_hs(input int h);
        return (h >= H_ACTIVE + H_FP) && (h < H_ACTIVE + H_FP + H_SYNC);
    endfunction

    function automatic bit in_vs(input int v);
        return (v >= V_ACTIVE + V_FP) && (v < V_ACTIVE + V_FP + V_SYNC);
    endfunction

    // Frame buffer holds {y[4:0], x zero-extended to 10 bits}; expected {r,g,b} derived field by field.
    function automatic logic [14:0] exp_rgb(input logic [7:0] x, input logic [7:0] y);
        return {x[4:0], 2'b00, x[7:5], y[4:0]};
    endfunction

    // Reference raster position and two-stage pipeline history.
    int mh = 0, mv = 0, mh_d1 = 0, mv_d1 = 0, mh_d2 = 0, mv_d2 = 0;
    bit v1 = 1'b0, v2 = 1'b0;

    initial forever begin
        @(posedge clk);
        if (rst) begin
            mh = 0; mv = 0; v1 = 1'b0; v2 = 1'b0;
        end else begin
            v2 = v1; mh_d2 = mh_d1; mv_d2 = mv_d1;
            v1 = 1'b1; mh_d1 = mh; mv_d1 = mv;
            if (mh == H_TOTAL - 1) begin
                mh = 0;
                mv = (mv == V_TOTAL - 1) ? 0 : mv + 1;
            end else begin
                mh = mh + 1;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        pix_data = pix_req ? {pix_y[4:0], 10'(pix_x)} : 15'($urandom);
    end

    bit          mon_en = 1'b0;
    int          st_err = 0, pipe_err = 0, sync_err = 0, sb_err = 0, rgb0_err = 0, sb_pops = 0;
    logic [14:0] sb_q[$];
    logic [14:0] sb_exp;
    int          frame_seen = 0;
    int acc_dots, acc_req, acc_hbi, acc_vbi, acc_vbl, acc_vs_low, acc_hs_low, acc_ovl, acc_vci, acc_match, acc_vci_line;
    int snap_dots, snap_req, snap_hbi, snap_vbi, snap_vbl, snap_vs_low, snap_hs_low, snap_ovl, snap_vci, snap_match, snap_vci_line;
    int   hs_start_h = -1, hs_run = 0, hs_len = -1;
    logic hs_prev = 1'b1;

    initial forever begin
        @(negedge clk);
        if (mon_en) begin
            if (rst) begin
                if ({frame_start, hblank_irq, vblank_irq, vcount_irq, hblank, vblank, vcount_match} !== 7'b0
                    || vcount !== 9'd0) st_err++;
            end else begin
                if (frame_start  !== (mh == 0 && mv == 0))                         st_err++;
                if (hblank_irq   !== (mh == H_ACTIVE))                             st_err++;
                if (vblank_irq   !== (mh == 0 && mv == V_ACTIVE))                  st_err++;
                if (vcount_irq   !== (mh == 0 && mv == int'(vcount_target)))       st_err++;
                if (hblank       !== (mh >= H_ACTIVE))                             st_err++;
                if (vblank       !== (mv >= V_ACTIVE))                             st_err++;
                if (vcount_match !== (mv == int'(vcount_target)))                  st_err++;
                if (vcount       !== 9'(mv))                                       st_err++;
            end
            if (pix_req !== (v1 && is_active(mh_d1, mv_d1))) pipe_err++;
            if (pix_req === 1'b1 && (pix_x !== 8'(mh_d1) || pix_y !== 8'(mv_d1))) pipe_err++;
            if (lcd_de !== (v2 && is_active(mh_d2, mv_d2))) sync_err++;
            if (lcd_hs !== !(v2 && in_hs(mh_d2)))           sync_err++;
            if (lcd_vs !== !(v2 && in_vs(mv_d2)))           sync_err++;

            if (lcd_de === 1'b1) begin
                if (sb_q.size() == 0) sb_err++;
                else begin
                    sb_exp = sb_q.pop_front();
                    sb_pops++;
                    if ({lcd_r, lcd_g, lcd_b} !== sb_exp) sb_err++;
                end
            end else if ({lcd_r, lcd_g, lcd_b} !== 15'd0) rgb0_err++;
            if (pix_req === 1'b1) sb_q.push_back(exp_rgb(pix_x, pix_y));
            if (rst) sb_q.delete();

            if (!lcd_hs && hs_prev) begin hs_start_h = mh; hs_run = 1; end
            else if (!lcd_hs)        hs_run++;
            else if (!hs_prev)       hs_len = hs_run;
            hs_prev = lcd_hs;

            if (!rst) begin
                if (frame_start) begin
                    snap_dots = acc_dots; snap_req = acc_req; snap_hbi = acc_hbi; snap_vbi = acc_vbi;
                    snap_vbl = acc_vbl; snap_vs_low = acc_vs_low; snap_hs_low = acc_hs_low; snap_ovl = acc_ovl;
                    snap_vci = acc_vci; snap_match = acc_match; snap_vci_line = acc_vci_line;
                    acc_dots = 0; acc_req = 0; acc_hbi = 0; acc_vbi = 0; acc_vbl = 0; acc_vs_low = 0;
                    acc_hs_low = 0; acc_ovl = 0; acc_vci = 0; acc_match = 0; acc_vci_line = -1;
                    frame_seen++;
                end
                acc_dots++;
                acc_req    += int'(pix_req);
                acc_hbi    += int'(hblank_irq);
                acc_vbi    += int'(vblank_irq);
                acc_vbl    += int'(vblank);
                acc_vs_low += int'(!lcd_vs);
                acc_hs_low += int'(!lcd_hs);
                acc_ovl    += int'(lcd_de && (!lcd_hs || !lcd_vs));
                acc_vci    += int'(vcount_irq);
                acc_match  += int'(vcount_match);
                if (vcount_irq) acc_vci_line = int'(vcount);
            end
        end
    end

    task automatic wait_frames(input int n, input string name);
        int budget = 3 * FRAME;
        while (frame_seen < n && budget > 0) begin
            @(negedge clk); #1;
            budget--;
        end
        if (budget == 0) check({name, "_timeout"}, frame_seen, n);
    endtask

    task automatic wait_dot(input int h, input int v, input string name);
        int budget = 2 * FRAME;
        do begin
            @(posedge clk); #1;
            budget--;
        end while (!(mh == h && mv == v) && budget > 0);
        if (budget == 0) check({name, "_timeout"}, mh * 1000 + mv, h * 1000 + v);
    endtask

    typedef struct {
        logic [8:0] target;
        int         exp_pulses;
        int         exp_match;
        int         exp_line;
    } vc_vec_t;

    vc_vec_t vc_tab[5];

    initial begin
        int base;
        vc_tab = '{
            '{9'd5,   1, H_TOTAL,  5},
            '{9'd0,   1, H_TOTAL,  0},
            '{9'd13,  1, H_TOTAL, 13},
            '{9'd14,  0, 0,       -1},
            '{9'd300, 0, 0,       -1}
        };

        // Reset held for 5 cycles, then released.
        rst = 1'b1;
        @(posedge clk); #1;
        mon_en = 1'b1;
        @(negedge clk); #1;
        check("rst_pix_req", pix_req, 0);
        check("rst_lcd_de", lcd_de, 0);
        check("rst_rgb", {lcd_r, lcd_g, lcd_b}, 0);
        check("rst_lcd_hs", lcd_hs, 1);
        check("rst_lcd_vs", lcd_vs, 1);
        check("rst_frame_start", frame_start, 0);
        repeat (4) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk); #1;
        check("release_frame_start", frame_start, 1);
        check("release_vcount", vcount, 0);

        // First full frame: period, fetch count, status pulses, sync shapes.
        wait_frames(2, "frame1");
        check("frame_period", snap_dots, FRAME);
        check("pix_req_count", snap_req, H_ACTIVE * V_ACTIVE);
        check("hblank_irq_count", snap_hbi, V_TOTAL);
        check("vblank_irq_count", snap_vbi, 1);
        check("vblank_level_dots", snap_vbl, (V_TOTAL - V_ACTIVE) * H_TOTAL);
        check("vs_low_dots", snap_vs_low, V_SYNC * H_TOTAL);
        check("hs_low_dots", snap_hs_low, V_TOTAL * H_SYNC);
        check("de_sync_overlap", snap_ovl, 0);
        check("hs_start_dot", hs_start_h, H_ACTIVE + H_FP + 2);
        check("hs_len", hs_len, H_SYNC);

        // VCOUNT compare table, each target applied for one whole frame.
        foreach (vc_tab[i]) begin
            wait_dot(H_TOTAL - 1, V_TOTAL - 1, "tab_align");
            vcount_target = vc_tab[i].target;
            base = frame_seen;
            wait_frames(base + 2, "tab_frame");
            check($sformatf("vc_irq_pulses[t=%0d]", vc_tab[i].target), snap_vci, vc_tab[i].exp_pulses);
            check($sformatf("vc_match_dots[t=%0d]", vc_tab[i].target), snap_match, vc_tab[i].exp_match);
            check($sformatf("vc_irq_line[t=%0d]", vc_tab[i].target), snap_vci_line, vc_tab[i].exp_line);
        end

        // pix_x/pix_y hold the last fetched coordinate through blanking.
        wait_dot(H_ACTIVE + 5, 3, "hold_h");
        @(negedge clk); #1;
        check("hold_hblank_req", pix_req, 0);
        check("hold_hblank_x", pix_x, H_ACTIVE - 1);
        check("hold_hblank_y", pix_y, 3);
        wait_dot(10, V_ACTIVE + 2, "hold_v");
        @(negedge clk); #1;
        check("hold_vblank_x", pix_x, H_ACTIVE - 1);
        check("hold_vblank_y", pix_y, V_ACTIVE - 1);

        // Reset mid-line aborts the frame; the panel side goes quiet at once.
        wait_dot(123, 5, "midline");
        rst = 1'b1;
        @(negedge clk); #1;
        check("midrst_vcount_forced", vcount, 0);
        check("midrst_hblank_forced", hblank, 0);
        @(negedge clk); #1;
        check("midrst_pix_req", pix_req, 0);
        check("midrst_lcd_de", lcd_de, 0);
        check("midrst_rgb", {lcd_r, lcd_g, lcd_b}, 0);
        check("midrst_lcd_hs", lcd_hs, 1);
        check("midrst_lcd_vs", lcd_vs, 1);
        @(posedge clk); #1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk); #1;
        check("midrst_restart_fs", frame_start, 1);
        check("midrst_no_stale_de", lcd_de, 0);
        base = frame_seen;
        wait_frames(base + 1, "midrst_frame");
        check("midrst_frame_period", snap_dots, FRAME);
        check("midrst_pix_req_count", snap_req, H_ACTIVE * V_ACTIVE);

        // Per-dot tracking and scoreboard totals.
        check("status_track_errors", st_err, 0);
        check("s1_track_errors", pipe_err, 0);
        check("sync_de_track_errors", sync_err, 0);
        check("scoreboard_rgb_errors", sb_err, 0);
        check("rgb_zero_when_idle_errors", rgb0_err, 0);
        check("scoreboard_has_traffic", int'(sb_pops >= 4 * H_ACTIVE * V_ACTIVE), 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
